execute_memory_reg: RTL and testbench

Execute-to-Memory pipeline register of the 5-stage RV32I core. It sits directly downstream of the Decode-to-Execute register and the execute datapath. It captures ALU result, store data and control, and tracks an instruction-valid bit. It runs a small wait FSM that holds the Memory stage while data memory is not ready, and raises a stall request to the hazard unit during that hold.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/mem_wait_fsm.sv | 29 ++
 rtl/execute_memory_reg.sv | 89 ++++++++
 tb/tb_execute_memory_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline encodings, Memory-stage wait states and the M-side control bundle
package pipeline_pkg;
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} exmem_state_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       mem_read;
    logic [2:0] funct3;
  } exmem_ctrl_t;
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: holds the Memory stage while a load/store waits on data memory (EXMEM_PERF_EN adds a wait-cycle counter)
module mem_wait_fsm
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic        mem_ready,
  output logic        mem_hold,
  output logic        mem_req
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0] wait_cycles
`endif
);
  exmem_state_t state;
  assign mem_req  = access & (state == WAIT | state == IDLE);
  assign mem_hold = (state == WAIT | access) & ~mem_ready;
  // stay in WAIT for as long as the outstanding access has not completed
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= mem_hold ? WAIT : IDLE;
`ifdef EXMEM_PERF_EN
  // saturating count of cycles spent in WAIT
  always_ff @(posedge clk)
    if (rst) wait_cycles <= '0;
    else if (state == WAIT && wait_cycles != '1) wait_cycles <= wait_cycles + 32'd1;
`endif
endmodule

// File: rtl/execute_memory_reg.sv
// execute_memory_reg: Execute-to-Memory pipeline register with memory wait hold (EXMEM_PERF_EN adds perf counters)
module execute_memory_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallM,
  input  logic                      FlushM,
  input  logic                      ValidE,
  input  logic                      RegWriteE,
  input  logic [1:0]                ResultSrcE,
  input  logic                      MemWriteE,
  input  logic                      MemReadE,
  input  logic [2:0]                Funct3E,
  input  logic [DATA_WIDTH-1:0]     ALUResultE,
  input  logic [DATA_WIDTH-1:0]     WriteDataE,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  input  logic                      MemReadyM,
  output logic                      ValidM,
  output logic                      RegWriteM,
  output logic [1:0]                ResultSrcM,
  output logic                      MemWriteM,
  output logic                      MemReadM,
  output logic [2:0]                Funct3M,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic                      MemReqM,
  output logic                      MemStallReqM
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0]               MemWaitCyclesM,
  output logic [31:0]               FlushCountM
`endif
);
  exmem_ctrl_t ctrl_q;
  logic valid_q;
  logic mem_hold;
  logic access;
  assign access       = valid_q & (ctrl_q.mem_read | ctrl_q.mem_write);
  assign ValidM       = valid_q;
  assign RegWriteM    = valid_q & ctrl_q.reg_write;
  assign ResultSrcM   = ctrl_q.result_src;
  assign MemWriteM    = valid_q & ctrl_q.mem_write;
  assign MemReadM     = valid_q & ctrl_q.mem_read;
  assign Funct3M      = ctrl_q.funct3;
  assign MemStallReqM = mem_hold;
  mem_wait_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .access      (access),
    .mem_ready   (MemReadyM),
    .mem_hold    (mem_hold),
    .mem_req     (MemReqM)
`ifdef EXMEM_PERF_EN
    ,
    .wait_cycles (MemWaitCyclesM)
`endif
  );
  // memory hold freezes everything and swallows flushes so an in-flight store is never torn
  always_ff @(posedge clk)
    if (rst || (FlushM && !mem_hold)) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else if (!mem_hold && !StallM) begin
      valid_q    <= ValidE;
      ctrl_q     <= '{reg_write: RegWriteE, result_src: ResultSrcE, mem_write: MemWriteE,
                      mem_read: MemReadE, funct3: Funct3E};
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
`ifdef EXMEM_PERF_EN
  // saturating count of flushes that actually inserted a bubble
  always_ff @(posedge clk)
    if (rst) FlushCountM <= '0;
    else if (FlushM && !mem_hold && FlushCountM != '1) FlushCountM <= FlushCountM + 32'd1;
`endif
endmodule

// File: tb/tb_execute_memory_reg.sv
// tb_execute_memory_reg: directed bench with a cycle-level reference model of the E->M register
module tb_execute_memory_reg;
  import pipeline_pkg::*;
  logic clk = 0, rst = 1, StallM = 0, FlushM = 0, ValidE = 0, RegWriteE = 0;
  logic MemWriteE = 0, MemReadE = 0, MemReadyM = 0;
  logic [1:0] ResultSrcE = 0;
  logic [2:0] Funct3E = 0;
  logic [31:0] ALUResultE = 0, WriteDataE = 0, PCPlus4E = 0;
  logic [4:0] RdE = 0;
  logic ValidM, RegWriteM, MemWriteM, MemReadM, MemReqM, MemStallReqM;
  logic [1:0] ResultSrcM;
  logic [2:0] Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0] RdM;
`ifdef EXMEM_PERF_EN
  logic [31:0] MemWaitCyclesM, FlushCountM;
`endif
  execute_memory_reg dut (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .Funct3E(Funct3E), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E), .MemReadyM(MemReadyM),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .MemReqM(MemReqM), .MemStallReqM(MemStallReqM)
`ifdef EXMEM_PERF_EN
    , .MemWaitCyclesM(MemWaitCyclesM), .FlushCountM(FlushCountM)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // reference model: what the M side must hold after each edge
  bit mv, mrw, mmw, mmr, known = 0, waiting = 0;
  bit [1:0] mrs;
  bit [2:0] mf3;
  bit [31:0] malu, mwd, mpc4;
  bit [4:0] mrd;
  int unsigned waits = 0, flushes = 0;
  function automatic bit busy();
    return mv && (mmr || mmw) && !MemReadyM;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      {mv, mrw, mrs, mmw, mmr, mf3, malu, mwd, mrd, mpc4} = '0;
      waiting = 0; waits = 0; flushes = 0; known = 1;
    end else begin
      if (waiting) waits++;
      waiting = busy();
      if (waiting) begin
      end else if (FlushM) begin
        {mv, mrw, mrs, mmw, mmr, mf3, malu, mwd, mrd, mpc4} = '0;
        flushes++;
      end else if (!StallM)
        {mv, mrw, mrs, mmw, mmr, mf3, malu, mwd, mrd, mpc4} =
          {ValidE, RegWriteE, ResultSrcE, MemWriteE, MemReadE, Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E};
    end
  end
  function automatic logic [127:0] exp_vec();
    bit req = mv && (mmr || mmw);
    return {mv, mv & mrw, mrs, mv & mmw, mv & mmr, mf3, malu, mwd, mrd, mpc4, req, req && !MemReadyM};
  endfunction
  logic [127:0] dut_vec;
  assign dut_vec = {ValidM, RegWriteM, ResultSrcM, MemWriteM, MemReadM, Funct3M,
                    ALUResultM, WriteDataM, RdM, PCPlus4M, MemReqM, MemStallReqM};
  always @(negedge clk)
    if (known) begin
      chk("cycle_outputs", dut_vec, exp_vec());
`ifdef EXMEM_PERF_EN
      chk("cycle_wait_count", MemWaitCyclesM, waits);
      chk("cycle_flush_count", FlushCountM, flushes);
`endif
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_e(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic mr, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4);
    {ValidE, RegWriteE, ResultSrcE, MemWriteE, MemReadE, Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E} =
      {v, rw, rs, mw, mr, f3, alu, wd, rd, pc4};
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int stalls;
    cyc(); cyc();
    chk("rst_valid", ValidM, 0);
    chk("rst_alu", ALUResultM, 0);
    chk("rst_stall", MemStallReqM, 0);
    rst = 0;
    set_e(1, 1, RESULT_ALU, 0, 0, 0, 32'h1234, 0, 5, 32'h8);
    cyc();
    chk("t1_valid", ValidM, 1);
    chk("t1_alu", ALUResultM, 32'h1234);
    chk("t1_rd", RdM, 5);
    chk("t1_regwrite", RegWriteM, 1);
    chk("t1_memreq", MemReqM, 0);
    chk("t1_nostall", MemStallReqM, 0);
    set_e(1, 1, RESULT_MEM, 0, 1, F3_W, 32'h100, 0, 7, 32'h10);
    cyc();
    set_e(1, 1, RESULT_ALU, 0, 0, 0, 32'h200, 0, 8, 32'h14);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      stalls += int'(MemStallReqM);
      chk("t2_frozen", ALUResultM, 32'h100);
      chk("t2_req", MemReqM, 1);
      cyc();
    end
    MemReadyM = 1;
    #1;
    chk("t2_ready_nostall", MemStallReqM, 0);
    chk("t2_stall_cycles", stalls, 3);
    chk("t2_still_frozen", ALUResultM, 32'h100);
    cyc();
    chk("t2_next_alu", ALUResultM, 32'h200);
    chk("t2_next_rd", RdM, 8);
`ifdef EXMEM_PERF_EN
    chk("t2_wait_cycles", MemWaitCyclesM, 3);
`endif
    FlushM = 1;
    set_e(1, 0, RESULT_ALU, 1, 0, F3_W, 32'h300, 32'hcafe, 0, 32'h18);
    cyc();
    chk("t3_valid", ValidM, 0);
    chk("t3_memwrite", MemWriteM, 0);
    chk("t3_regwrite", RegWriteM, 0);
    chk("t3_memreq", MemReqM, 0);
    FlushM = 0;
    MemReadyM = 0;
    set_e(1, 0, RESULT_ALU, 1, 0, F3_W, 32'h300, 32'hdeadbeef, 0, 32'h1c);
    cyc();
    FlushM = 1;
    set_e(1, 1, RESULT_ALU, 0, 0, 0, 32'h999, 0, 3, 0);
    cyc();
    chk("t4_store_kept", MemWriteM, 1);
    chk("t4_store_data", WriteDataM, 32'hdeadbeef);
    cyc();
    chk("t4_store_kept2", MemWriteM, 1);
    chk("t4_valid_kept", ValidM, 1);
    MemReadyM = 1;
    cyc();
    chk("t4_flush_after", ValidM, 0);
    FlushM = 0;
    set_e(1, 1, RESULT_ALU, 0, 0, 0, 32'h500, 0, 9, 32'h20);
    cyc();
    StallM = 1;
    set_e(1, 1, RESULT_PC4, 0, 0, 0, 32'h600, 0, 10, 32'h24);
    cyc();
    chk("t5_stall1", ALUResultM, 32'h500);
    set_e(1, 0, RESULT_ALU, 0, 0, 0, 32'h700, 0, 11, 32'h28);
    cyc();
    chk("t5_stall2_alu", ALUResultM, 32'h500);
    chk("t5_stall2_rd", RdM, 9);
    FlushM = 1;
    cyc();
    chk("t5_flush_wins", ValidM, 0);
    StallM = 0;
    FlushM = 0;
    set_e(0, 1, RESULT_MEM, 1, 1, F3_H, 32'h40, 32'h41, 4, 32'h2c);
    cyc();
    chk("gate_regwrite", RegWriteM, 0);
    chk("gate_memwrite", MemWriteM, 0);
    chk("gate_memreq", MemReqM, 0);
    chk("gate_alu", ALUResultM, 32'h40);
    MemReadyM = 0;
    set_e(1, 0, RESULT_ALU, 1, 0, F3_B, 32'h800, 32'h55, 0, 32'h30);
    cyc();
    set_e(1, 1, RESULT_ALU, 0, 0, 0, 32'h900, 0, 13, 32'h34);
    cyc();
    chk("t6_waiting", MemStallReqM, 1);
    rst = 1;
    cyc();
    chk("t6_valid", ValidM, 0);
    chk("t6_memwrite", MemWriteM, 0);
    chk("t6_stall", MemStallReqM, 0);
    chk("t6_alu", ALUResultM, 0);
`ifdef EXMEM_PERF_EN
    chk("t6_wait_cleared", MemWaitCyclesM, 0);
`endif
    rst = 0;
    set_e(1, 1, RESULT_MEM, 0, 1, F3_BU, 32'hA00, 0, 11, 32'h38);
    cyc();
    set_e(1, 1, RESULT_MEM, 0, 1, F3_HU, 32'hB00, 0, 12, 32'h3c);
    cyc();
    MemReadyM = 1;
    cyc();
    chk("b2b_alu", ALUResultM, 32'hB00);
    chk("b2b_valid", ValidM, 1);
    chk("b2b_memread", MemReadM, 1);
    chk("b2b_req", MemReqM, 1);
    set_e(0, 0, RESULT_ALU, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
